// File: rtl/bram_arbiter_if.sv
// Request, response and BRAM-side signals shared between the arbiter and its neighbours.
interface bram_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic              cpu_req_valid, cpu_req_ready, cpu_req_we;
  logic [ADDR_W-1:0] cpu_req_addr;
  logic [DATA_W-1:0] cpu_req_wdata;
  logic              dbg_req_valid, dbg_req_ready, dbg_req_we;
  logic [ADDR_W-1:0] dbg_req_addr;
  logic [DATA_W-1:0] dbg_req_wdata;
  logic              cpu_rsp_valid, dbg_rsp_valid;
  logic [DATA_W-1:0] cpu_rsp_rdata, dbg_rsp_rdata;
  logic              bram_en, bram_we;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_wdata, bram_rdata;
  logic              dbg_starved;

  // arbiter side
  modport slave (
    input  cpu_req_valid, cpu_req_we, cpu_req_addr, cpu_req_wdata,
    input  dbg_req_valid, dbg_req_we, dbg_req_addr, dbg_req_wdata,
    output cpu_req_ready, dbg_req_ready,
    output cpu_rsp_valid, cpu_rsp_rdata, dbg_rsp_valid, dbg_rsp_rdata,
    output bram_en, bram_we, bram_addr, bram_wdata,
    input  bram_rdata,
    output dbg_starved
  );

  // requester / BRAM side
  modport master (
    output cpu_req_valid, cpu_req_we, cpu_req_addr, cpu_req_wdata,
    output dbg_req_valid, dbg_req_we, dbg_req_addr, dbg_req_wdata,
    input  cpu_req_ready, dbg_req_ready,
    input  cpu_rsp_valid, cpu_rsp_rdata, dbg_rsp_valid, dbg_rsp_rdata,
    input  bram_en, bram_we, bram_addr, bram_wdata,
    output bram_rdata,
    input  dbg_starved
  );
endinterface

// File: rtl/bram_arbiter.sv
// Two-port (CPU / debug) arbiter onto a single-port BRAM with one-cycle read latency.
// ARB_MODE 0: round-robin on conflict. ARB_MODE 1: CPU first, debug force-granted
// after MAX_WAIT consecutive stalled cycles.
module bram_arbiter #(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 32,
  parameter int ARB_MODE = 0,
  parameter int MAX_WAIT = 8
) (
  input logic           ap_clk,
  input logic           ap_rst_n,
  bram_arbiter_if.slave bus
);
  localparam int WCW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam int CPU = 0;
  localparam int DBG = 1;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  logic [1:0]     vld, gnt;
  req_t [1:0]     req;
  req_t           sel;
  logic           last_grant;  // 1 = debug was granted most recently
  logic [WCW-1:0] wait_cnt;
  logic           starved;
  logic           rsp_pend, rsp_sel, rsp_we;

  assign vld      = {bus.dbg_req_valid, bus.cpu_req_valid};
  assign req[CPU] = {bus.cpu_req_we, bus.cpu_req_addr, bus.cpu_req_wdata};
  assign req[DBG] = {bus.dbg_req_we, bus.dbg_req_addr, bus.dbg_req_wdata};
  assign starved  = (ARB_MODE == 1) && (wait_cnt == WCW'(MAX_WAIT));

  // Grant: a lone requester wins outright; conflicts go by mode. Held off during reset
  // so every output reads 0 while ap_rst_n is low.
  always_comb begin
    gnt = '0;
    if (ap_rst_n) begin
      case (vld)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11: begin
          if (ARB_MODE == 0) gnt = last_grant ? 2'b01 : 2'b10;
          else               gnt = starved    ? 2'b10 : 2'b01;
        end
        default: gnt = '0;
      endcase
    end
  end

  // Route the granted request onto the BRAM port; idle bus drives zeros.
  always_comb begin
    sel = '0;
    if (gnt[CPU])      sel = req[CPU];
    else if (gnt[DBG]) sel = req[DBG];
  end

  assign bus.bram_en       = |gnt;
  assign bus.bram_we       = sel.we;
  assign bus.bram_addr     = sel.addr;
  assign bus.bram_wdata    = sel.wdata;
  assign bus.cpu_req_ready = gnt[CPU];
  assign bus.dbg_req_ready = gnt[DBG];

  // Response stage and round-robin history: capture each grant for its one-cycle-later reply.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      rsp_pend   <= 1'b0;
      rsp_sel    <= 1'b0;
      rsp_we     <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      rsp_pend <= |gnt;
      if (|gnt) begin
        rsp_sel    <= gnt[DBG];
        rsp_we     <= sel.we;
        last_grant <= gnt[DBG];
      end
    end
  end

  // Starvation counter: counts consecutive stalled debug cycles, saturating at MAX_WAIT.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n)                              wait_cnt <= '0;
    else if (ARB_MODE != 1)                     wait_cnt <= '0;
    else if (!bus.dbg_req_valid || gnt[DBG])    wait_cnt <= '0;
    else if (wait_cnt != WCW'(MAX_WAIT))        wait_cnt <= wait_cnt + WCW'(1);
  end

  assign bus.cpu_rsp_valid = rsp_pend & ~rsp_sel;
  assign bus.dbg_rsp_valid = rsp_pend &  rsp_sel;
  assign bus.cpu_rsp_rdata = (bus.cpu_rsp_valid && !rsp_we) ? bus.bram_rdata : '0;
  assign bus.dbg_rsp_rdata = (bus.dbg_rsp_valid && !rsp_we) ? bus.bram_rdata : '0;
  assign bus.dbg_starved   = starved;
endmodule

// File: tb/tb_bram_arbiter.sv
// Bench for bram_arbiter: a round-robin instance and a CPU-priority instance run side by
// side on identical stimulus, each against its own BRAM model and a cycle-level reference.
module tb_bram_arbiter;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int MW = 8;
  localparam int DEPTH = 1 << AW;

  logic ap_clk = 1'b0;
  logic ap_rst_n = 1'b0;
  always #5 ap_clk = ~ap_clk;

  // shared stimulus
  logic          c_v = 0, c_we = 0, d_v = 0, d_we = 0;
  logic [AW-1:0] c_a = '0, d_a = '0;
  logic [DW-1:0] c_d = '0, d_d = '0;

  bram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus0 ();
  bram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();

  bram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ARB_MODE(0), .MAX_WAIT(MW)) dut0 (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .bus(bus0.slave));
  bram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ARB_MODE(1), .MAX_WAIT(MW)) dut1 (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .bus(bus1.slave));

  assign bus0.cpu_req_valid = c_v;  assign bus1.cpu_req_valid = c_v;
  assign bus0.cpu_req_we    = c_we; assign bus1.cpu_req_we    = c_we;
  assign bus0.cpu_req_addr  = c_a;  assign bus1.cpu_req_addr  = c_a;
  assign bus0.cpu_req_wdata = c_d;  assign bus1.cpu_req_wdata = c_d;
  assign bus0.dbg_req_valid = d_v;  assign bus1.dbg_req_valid = d_v;
  assign bus0.dbg_req_we    = d_we; assign bus1.dbg_req_we    = d_we;
  assign bus0.dbg_req_addr  = d_a;  assign bus1.dbg_req_addr  = d_a;
  assign bus0.dbg_req_wdata = d_d;  assign bus1.dbg_req_wdata = d_d;

  // DUT outputs gathered into arrays so the reference loop can index them
  logic [1:0]    o_crdy, o_drdy, o_en, o_we, o_crv, o_drv, o_st;
  logic [AW-1:0] o_addr [2];
  logic [DW-1:0] o_wd [2], o_crd [2], o_drd [2], brd [2];
  assign o_crdy[0] = bus0.cpu_req_ready; assign o_crdy[1] = bus1.cpu_req_ready;
  assign o_drdy[0] = bus0.dbg_req_ready; assign o_drdy[1] = bus1.dbg_req_ready;
  assign o_en[0]   = bus0.bram_en;       assign o_en[1]   = bus1.bram_en;
  assign o_we[0]   = bus0.bram_we;       assign o_we[1]   = bus1.bram_we;
  assign o_crv[0]  = bus0.cpu_rsp_valid; assign o_crv[1]  = bus1.cpu_rsp_valid;
  assign o_drv[0]  = bus0.dbg_rsp_valid; assign o_drv[1]  = bus1.dbg_rsp_valid;
  assign o_st[0]   = bus0.dbg_starved;   assign o_st[1]   = bus1.dbg_starved;
  assign o_addr[0] = bus0.bram_addr;     assign o_addr[1] = bus1.bram_addr;
  assign o_wd[0]   = bus0.bram_wdata;    assign o_wd[1]   = bus1.bram_wdata;
  assign o_crd[0]  = bus0.cpu_rsp_rdata; assign o_crd[1]  = bus1.cpu_rsp_rdata;
  assign o_drd[0]  = bus0.dbg_rsp_rdata; assign o_drd[1]  = bus1.dbg_rsp_rdata;
  assign bus0.bram_rdata = brd[0];       assign bus1.bram_rdata = brd[1];

  // BRAM models: registered read, write on enable
  logic [DW-1:0] bmem [2][DEPTH];
  always @(posedge ap_clk)
    for (int m = 0; m < 2; m++)
      if (o_en[m]) begin
        if (o_we[m]) bmem[m][o_addr[m]] <= o_wd[m];
        else         brd[m] <= bmem[m][o_addr[m]];
      end

  int n_vec = 0;
  int n_err = 0;

  // reference model state (per instance)
  logic [DW-1:0] rmem [2][DEPTH];
  int            m_last [2];    // 0 = cpu, 1 = dbg granted most recently
  int            m_streak [2];  // consecutive cycles the debug request was left waiting
  bit            m_pend [2];
  int            m_sel [2];
  bit            m_rd [2];
  logic [DW-1:0] m_data [2];
  int            g;
  bit            exp_st;

  // Reference: each falling edge, derive the expected grant from the arbitration rules and
  // compare every DUT output, then advance the model by one cycle.
  always @(negedge ap_clk) begin
    for (int m = 0; m < 2; m++) begin
      if (!ap_rst_n) begin
        n_vec++;
        if ({o_crdy[m], o_drdy[m], o_en[m], o_we[m], o_crv[m], o_drv[m], o_st[m]} !== 7'd0 ||
            o_addr[m] !== '0 || o_wd[m] !== '0 || o_crd[m] !== '0 || o_drd[m] !== '0) begin
          n_err++;
          $display("FAIL reset_outputs dut%0d: rdy=%b%b en=%b we=%b rv=%b%b st=%b addr=%h, want all 0",
                   m, o_crdy[m], o_drdy[m], o_en[m], o_we[m], o_crv[m], o_drv[m], o_st[m], o_addr[m]);
        end
        m_pend[m] = 0; m_last[m] = 1; m_streak[m] = 0;
      end else begin
        g = -1;
        if (c_v && d_v) begin
          if (m == 0) g = (m_last[m] == 0) ? 1 : 0;
          else        g = (m_streak[m] >= MW) ? 1 : 0;
        end else if (c_v) g = 0;
        else if (d_v)     g = 1;

        n_vec++;
        if (o_crdy[m] !== (g == 0) || o_drdy[m] !== (g == 1)) begin
          n_err++;
          $display("FAIL grant dut%0d t=%0t: ready cpu/dbg=%b%b, want %b%b",
                   m, $time, o_crdy[m], o_drdy[m], g == 0, g == 1);
        end
        n_vec++;
        if (o_en[m] !== (g >= 0)) begin
          n_err++;
          $display("FAIL bram_en dut%0d t=%0t: got %b want %b", m, $time, o_en[m], g >= 0);
        end
        if (g >= 0) begin
          n_vec++;
          if ({o_we[m], o_addr[m], o_wd[m]} !== (g == 0 ? {c_we, c_a, c_d} : {d_we, d_a, d_d})) begin
            n_err++;
            $display("FAIL bram_bus dut%0d t=%0t: we/addr/wdata=%b/%h/%h, want port %0d's",
                     m, $time, o_we[m], o_addr[m], o_wd[m], g);
          end
        end else begin
          n_vec++;
          if (o_we[m] !== 1'b0) begin
            n_err++;
            $display("FAIL idle_we dut%0d t=%0t: got %b want 0", m, $time, o_we[m]);
          end
        end
        n_vec++;
        if (o_crv[m] !== (m_pend[m] && m_sel[m] == 0) || o_drv[m] !== (m_pend[m] && m_sel[m] == 1)) begin
          n_err++;
          $display("FAIL rsp_valid dut%0d t=%0t: cpu/dbg=%b%b, want %b%b", m, $time, o_crv[m], o_drv[m],
                   m_pend[m] && m_sel[m] == 0, m_pend[m] && m_sel[m] == 1);
        end
        if (m_pend[m] && m_rd[m]) begin
          n_vec++;
          if ((m_sel[m] == 0 ? o_crd[m] : o_drd[m]) !== m_data[m]) begin
            n_err++;
            $display("FAIL rsp_rdata dut%0d t=%0t: got %h want %h", m, $time,
                     (m_sel[m] == 0 ? o_crd[m] : o_drd[m]), m_data[m]);
          end
        end
        exp_st = (m == 1) && (m_streak[m] >= MW);
        n_vec++;
        if (o_st[m] !== exp_st) begin
          n_err++;
          $display("FAIL dbg_starved dut%0d t=%0t: got %b want %b", m, $time, o_st[m], exp_st);
        end

        // advance model
        m_pend[m] = (g >= 0);
        if (g >= 0) begin
          m_sel[m]  = g;
          m_last[m] = g;
          m_rd[m]   = (g == 0) ? !c_we : !d_we;
          if (m_rd[m]) m_data[m] = rmem[m][g == 0 ? c_a : d_a];
          else if (g == 0) rmem[m][c_a] = c_d;
          else             rmem[m][d_a] = d_d;
        end
        m_streak[m] = (d_v && g != 1) ? m_streak[m] + 1 : 0;
      end
    end
  end

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic drive(input logic cv, input logic cwe, input logic [AW-1:0] ca, input logic [DW-1:0] cd,
                       input logic dv, input logic dwe, input logic [AW-1:0] da, input logic [DW-1:0] dd);
    c_v = cv; c_we = cwe; c_a = ca; c_d = cd;
    d_v = dv; d_we = dwe; d_a = da; d_d = dd;
  endtask

  task automatic do_reset();
    drive(0, 0, '0, '0, 0, 0, '0, '0);
    ap_rst_n = 1'b0;
    repeat (2) tick();
    ap_rst_n = 1'b1;
  endtask

  // Outputs stay 0 in reset even with both requests valid; first grant right after release.
  task automatic test_reset();
    ap_rst_n = 1'b0;
    drive(1, 1, 10'd1, 32'h1111, 1, 0, 10'd2, '0);
    #1;
    for (int m = 0; m < 2; m++) begin
      n_vec++;
      if ({o_crdy[m], o_drdy[m], o_en[m], o_crv[m], o_drv[m], o_st[m]} !== 6'd0) begin
        n_err++;
        $display("FAIL test_reset dut%0d: rdy=%b%b en=%b rv=%b%b st=%b, want 0",
                 m, o_crdy[m], o_drdy[m], o_en[m], o_crv[m], o_drv[m], o_st[m]);
      end
    end
    tick();
    ap_rst_n = 1'b1;
    drive(0, 0, '0, '0, 1, 0, 10'd9, '0);
    @(negedge ap_clk);
    for (int m = 0; m < 2; m++) begin
      n_vec++;
      if (o_drdy[m] !== 1'b1) begin
        n_err++;
        $display("FAIL first_grant dut%0d: dbg_ready=%b want 1", m, o_drdy[m]);
      end
    end
    tick();
    drive(0, 0, '0, '0, 0, 0, '0, '0);
    tick();
  endtask

  // CPU writes 0xDEADBEEF to 5 then reads it back.
  task automatic test_cpu_rw();
    do_reset();
    drive(1, 1, 10'd5, 32'hDEADBEEF, 0, 0, '0, '0);
    tick();
    drive(1, 0, 10'd5, '0, 0, 0, '0, '0);
    @(negedge ap_clk);
    for (int m = 0; m < 2; m++) begin
      n_vec++;
      if (o_crv[m] !== 1'b1) begin
        n_err++;
        $display("FAIL cpu_wr_rsp dut%0d: cpu_rsp_valid=%b want 1", m, o_crv[m]);
      end
    end
    tick();
    drive(0, 0, '0, '0, 0, 0, '0, '0);
    @(negedge ap_clk);
    for (int m = 0; m < 2; m++) begin
      n_vec++;
      if (o_crv[m] !== 1'b1 || o_crd[m] !== 32'hDEADBEEF) begin
        n_err++;
        $display("FAIL cpu_rd_rsp dut%0d: valid=%b data=%h want 1/deadbeef", m, o_crv[m], o_crd[m]);
      end
    end
    tick();
    @(negedge ap_clk);
    for (int m = 0; m < 2; m++) begin
      n_vec++;
      if (o_crv[m] !== 1'b0) begin
        n_err++;
        $display("FAIL cpu_rsp_pulse dut%0d: valid=%b want 0", m, o_crv[m]);
      end
    end
    tick();
  endtask

  // Round-robin: both valid for 4 cycles after reset gives CPU, DBG, CPU, DBG.
  task automatic test_conflict_rr();
    int nc = 0, nd = 0;
    do_reset();
    for (int k = 0; k < 6; k++) begin
      if (k < 4) drive(1, 0, AW'(k), '0, 1, 0, AW'(k + 100), '0);
      else       drive(0, 0, '0, '0, 0, 0, '0, '0);
      @(negedge ap_clk);
      if (k < 4) begin
        n_vec++;
        if (o_crdy[0] !== (k % 2 == 0) || o_drdy[0] !== (k % 2 == 1)) begin
          n_err++;
          $display("FAIL rr_order k=%0d: cpu/dbg ready=%b%b want %b%b", k, o_crdy[0], o_drdy[0],
                   k % 2 == 0, k % 2 == 1);
        end
      end
      nc += int'(o_crv[0]);
      nd += int'(o_drv[0]);
      tick();
    end
    n_vec++;
    if (nc != 2 || nd != 2) begin
      n_err++;
      $display("FAIL rr_rsp_count: cpu=%0d dbg=%0d want 2/2", nc, nd);
    end
  endtask

  // Priority mode: 8 CPU grants, then a forced DBG grant with dbg_starved, then CPU again.
  task automatic test_starvation();
    do_reset();
    drive(1, 0, 10'd20, '0, 1, 0, 10'd30, '0);
    for (int k = 0; k < 10; k++) begin
      @(negedge ap_clk);
      n_vec++;
      if (o_crdy[1] !== (k != 8) || o_drdy[1] !== (k == 8) || o_st[1] !== (k == 8)) begin
        n_err++;
        $display("FAIL starvation k=%0d: cpu/dbg ready=%b%b starved=%b, want %b%b%b",
                 k, o_crdy[1], o_drdy[1], o_st[1], k != 8, k == 8, k == 8);
      end
      tick();
    end
    drive(0, 0, '0, '0, 0, 0, '0, '0);
    tick();
  endtask

  // Write then read of the same address on consecutive cycles, from different ports.
  task automatic test_back_to_back();
    do_reset();
    drive(0, 0, '0, '0, 1, 1, 10'd7, 32'hCAFE0007);
    tick();
    drive(1, 0, 10'd7, '0, 0, 0, '0, '0);
    tick();
    drive(0, 0, '0, '0, 0, 0, '0, '0);
    @(negedge ap_clk);
    for (int m = 0; m < 2; m++) begin
      n_vec++;
      if (o_crv[m] !== 1'b1 || o_crd[m] !== 32'hCAFE0007) begin
        n_err++;
        $display("FAIL raw_order dut%0d: valid=%b data=%h want 1/cafe0007", m, o_crv[m], o_crd[m]);
      end
    end
    tick();
  endtask

  // Random mixed traffic over a narrow address window to provoke hazards; the reference checks it.
  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      drive(($urandom % 4) != 0, $urandom % 2, AW'($urandom % 16), $urandom,
            ($urandom % 3) != 0, $urandom % 2, AW'($urandom % 16), $urandom);
      tick();
    end
    drive(0, 0, '0, '0, 0, 0, '0, '0);
    tick();
  endtask

  // Debug dump of every address with the CPU idle: one gap-free response per cycle.
  task automatic test_dump();
    int pulses = 0;
    for (int k = 0; k <= DEPTH; k++) begin
      if (k < DEPTH) drive(0, 0, '0, '0, 1, 0, AW'(k), '0);
      else           drive(0, 0, '0, '0, 0, 0, '0, '0);
      @(negedge ap_clk);
      if (k > 0) begin
        pulses += int'(o_drv[0]);
        n_vec++;
        if (o_drv[0] !== 1'b1 || o_drd[0] !== rmem[0][k-1]) begin
          n_err++;
          $display("FAIL dump addr=%0d: valid=%b data=%h want 1/%h", k - 1, o_drv[0], o_drd[0], rmem[0][k-1]);
        end
      end
      tick();
    end
    n_vec++;
    if (pulses != DEPTH) begin
      n_err++;
      $display("FAIL dump_count: got %0d want %0d", pulses, DEPTH);
    end
  endtask

  // Reset the cycle after a grant: the pending response is dropped, outputs clear at once.
  task automatic test_reset_mid();
    do_reset();
    drive(1, 0, 10'd3, '0, 0, 0, '0, '0);
    tick();
    ap_rst_n = 1'b0;
    #1;
    for (int m = 0; m < 2; m++) begin
      n_vec++;
      if ({o_crdy[m], o_en[m], o_crv[m], o_drv[m]} !== 4'd0 || o_crd[m] !== '0) begin
        n_err++;
        $display("FAIL mid_reset_async dut%0d: rdy=%b en=%b rv=%b%b rdata=%h, want 0",
                 m, o_crdy[m], o_en[m], o_crv[m], o_drv[m], o_crd[m]);
      end
    end
    tick();
    drive(0, 0, '0, '0, 0, 0, '0, '0);
    tick();
    ap_rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge ap_clk);
      for (int m = 0; m < 2; m++) begin
        n_vec++;
        if (o_crv[m] !== 1'b0 || o_drv[m] !== 1'b0) begin
          n_err++;
          $display("FAIL stale_rsp dut%0d: rv=%b%b want 00", m, o_crv[m], o_drv[m]);
        end
      end
      tick();
    end
    drive(1, 0, 10'd3, '0, 0, 0, '0, '0);
    tick();
    drive(0, 0, '0, '0, 0, 0, '0, '0);
    @(negedge ap_clk);
    for (int m = 0; m < 2; m++) begin
      n_vec++;
      if (o_crv[m] !== 1'b1 || o_crd[m] !== rmem[m][3]) begin
        n_err++;
        $display("FAIL post_reset_read dut%0d: valid=%b data=%h want 1/%h", m, o_crv[m], o_crd[m], rmem[m][3]);
      end
    end
    tick();
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      logic [DW-1:0] v;
      v = $urandom;
      for (int m = 0; m < 2; m++) begin
        bmem[m][i] = v;
        rmem[m][i] = v;
      end
    end
    brd[0] = '0;
    brd[1] = '0;
    test_reset();
    test_cpu_rw();
    test_conflict_rr();
    test_starvation();
    test_back_to_back();
    test_random();
    test_dump();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
